// File: rtl/samp_pkg.sv
// rtl/samp_pkg.sv - shared constants and state encoding for the sample packer
package samp_pkg;

    localparam int WORD_W          = 128;
    localparam int LANE_COMP_W     = 16;
    localparam int LANE_W          = 4 * LANE_COMP_W;
    localparam int BATCH_WORDS_DEF = 8192;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } samp_state_t;

endpackage

// File: rtl/samp_pack.sv
// rtl/samp_pack.sv - packs dual-channel I/Q sample sets into 128-bit words per capture batch
module samp_pack
    import samp_pkg::*;
#(
    parameter int SAMP_WIDTH  = 12,
    parameter int BATCH_WORDS = BATCH_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [SAMP_WIDTH-1:0] in_i0,
    input  logic [SAMP_WIDTH-1:0] in_q0,
    input  logic [SAMP_WIDTH-1:0] in_i1,
    input  logic [SAMP_WIDTH-1:0] in_q1,
    output logic                  valid,
    output logic [WORD_W-1:0]     samp_out,
    output logic                  busy,
    output logic                  done
);

    localparam logic [15:0] BATCH_LIM = 16'(BATCH_WORDS);

    samp_state_t         state_q, state_d;
    logic                valid_q, valid_d;
    logic [WORD_W-1:0]   samp_out_q, samp_out_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                half_q, half_d;
    logic [LANE_W-1:0]   lo_q, lo_d;
    logic [LANE_W-1:0]   lane;

    assign lane = {LANE_COMP_W'(signed'(in_q1)), LANE_COMP_W'(signed'(in_i1)),
                   LANE_COMP_W'(signed'(in_q0)), LANE_COMP_W'(signed'(in_i0))};

    always_comb begin
        state_d    = state_q;
        valid_d    = 1'b0;
        samp_out_d = samp_out_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        lo_d       = lo_q;
        case (state_q)
            ST_IDLE: begin
                half_d = 1'b0;
                cnt_d  = 16'd0;
                if (start && !abort) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    lo_d    = lane;
                    half_d  = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // abort wins even over the lane that would complete a word
                if (abort) begin
                    state_d = ST_IDLE;
                    half_d  = 1'b0;
                end else if (in_valid) begin
                    if (half_q) begin
                        samp_out_d = {lane, lo_q};
                        valid_d    = 1'b1;
                        half_d     = 1'b0;
                        cnt_d      = cnt_q + 16'd1;
                        if (cnt_d == BATCH_LIM) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        lo_d   = lane;
                        half_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            samp_out_q <= '0;
            cnt_q      <= 16'd0;
            half_q     <= 1'b0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            samp_out_q <= samp_out_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            lo_q       <= lo_d;
        end
    end

    assign valid    = valid_q;
    assign samp_out = samp_out_q;
    assign busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign done     = (state_q == ST_DONE);

endmodule
